// File: rtl/matmul_gen.sv
`default_nettype none
// ============================================================================
// Module   : matmul_gen
// Brief    : Sequential Z = X*Y engine over internal X/Y/Z memories, one MAC
//            per cycle, signed wrap-around arithmetic.
// Revision : 1.0
// ============================================================================
module matmul_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int M_DIM      = 8,
    parameter int K_DIM      = 8,
    parameter int N_DIM      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] x_din,
    input  logic [ADDR_WIDTH-1:0] x_wr_addr,
    input  logic                  x_wr_en,
    input  logic [DATA_WIDTH-1:0] y_din,
    input  logic [ADDR_WIDTH-1:0] y_wr_addr,
    input  logic                  y_wr_en,
    input  logic [ADDR_WIDTH-1:0] z_rd_addr,
    output logic [DATA_WIDTH-1:0] z_dout,
    output logic                  wr_reject
);
    localparam int MK = M_DIM * K_DIM;
    localparam int KN = K_DIM * N_DIM;
    localparam int MN = M_DIM * N_DIM;
    localparam int XW = (MK > 1) ? $clog2(MK) : 1;
    localparam int YW = (KN > 1) ? $clog2(KN) : 1;
    localparam int ZW = (MN > 1) ? $clog2(MN) : 1;

    localparam logic [ADDR_WIDTH:0]   c_MK     = (ADDR_WIDTH+1)'(MK);
    localparam logic [ADDR_WIDTH:0]   c_KN     = (ADDR_WIDTH+1)'(KN);
    localparam logic [ADDR_WIDTH:0]   c_MN     = (ADDR_WIDTH+1)'(MN);
    localparam logic [ADDR_WIDTH-1:0] c_K      = ADDR_WIDTH'(K_DIM);
    localparam logic [ADDR_WIDTH-1:0] c_N      = ADDR_WIDTH'(N_DIM);
    localparam logic [ADDR_WIDTH-1:0] c_K_LAST = ADDR_WIDTH'(K_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] c_M_LAST = ADDR_WIDTH'(M_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] c_N_LAST = ADDR_WIDTH'(N_DIM - 1);

    generate
        if (M_DIM < 1 || K_DIM < 1 || N_DIM < 1 ||
            MK > (1 << ADDR_WIDTH) || KN > (1 << ADDR_WIDTH) || MN > (1 << ADDR_WIDTH)) begin : g_bad_dims
            $error("matmul_gen: dimensions do not fit ADDR_WIDTH or are zero");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_reject;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_zdout;
    logic [DATA_WIDTH-1:0] r_xq;
    logic [DATA_WIDTH-1:0] r_yq;
    logic [ADDR_WIDTH-1:0] r_k;
    logic [ADDR_WIDTH-1:0] r_i;
    logic [ADDR_WIDTH-1:0] r_j;
    logic [ADDR_WIDTH-1:0] r_xrow;
    logic [ADDR_WIDTH-1:0] r_xa;
    logic [ADDR_WIDTH-1:0] r_ya;
    logic [ADDR_WIDTH-1:0] r_za;

    logic [DATA_WIDTH-1:0] r_x_mem [0:MK-1];
    logic [DATA_WIDTH-1:0] r_y_mem [0:KN-1];
    logic [DATA_WIDTH-1:0] r_z_mem [0:MN-1];

    logic                  w_x_wr;
    logic                  w_y_wr;
    logic                  w_reject;
    logic [DATA_WIDTH-1:0] w_prod;

    assign w_x_wr   = x_wr_en && !r_busy && ({1'b0, x_wr_addr} < c_MK);
    assign w_y_wr   = y_wr_en && !r_busy && ({1'b0, y_wr_addr} < c_KN);
    assign w_reject = (x_wr_en && !w_x_wr) || (y_wr_en && !w_y_wr);
    // Low DATA_WIDTH bits of the product are identical for signed and unsigned operands.
    assign w_prod   = r_xq * r_yq;

    // Memories carry no reset so contents survive a mid-run reset.
    always_ff @(posedge clock) begin
        if (w_x_wr) r_x_mem[x_wr_addr[XW-1:0]] <= x_din;
        if (w_y_wr) r_y_mem[y_wr_addr[YW-1:0]] <= y_din;
        if (r_state == S_STORE) r_z_mem[r_za[ZW-1:0]] <= r_acc;
        r_xq <= r_x_mem[r_xa[XW-1:0]];
        r_yq <= r_y_mem[r_ya[YW-1:0]];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_reject <= 1'b0;
            r_acc       <= '0;
            r_zdout     <= '0;
            r_k         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_xrow      <= '0;
            r_xa        <= '0;
            r_ya        <= '0;
            r_za        <= '0;
        end else begin
            r_wr_reject <= w_reject;
            r_zdout     <= ({1'b0, z_rd_addr} < c_MN) ? r_z_mem[z_rd_addr[ZW-1:0]] : '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                        r_k     <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_xrow  <= '0;
                        r_xa    <= '0;
                        r_ya    <= '0;
                        r_za    <= '0;
                    end
                end
                S_FETCH: begin
                    // Cycle k=0 has no product in flight for this element yet.
                    r_acc <= (r_k == '0) ? '0 : r_acc + w_prod;
                    if (r_k == c_K_LAST) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_k  <= r_k + 1'b1;
                        r_xa <= r_xa + 1'b1;
                        r_ya <= r_ya + c_N;
                    end
                end
                S_DRAIN: begin
                    r_acc   <= r_acc + w_prod;
                    r_state <= S_STORE;
                end
                S_STORE: begin
                    r_k  <= '0;
                    r_za <= r_za + 1'b1;
                    if (r_i == c_M_LAST && r_j == c_N_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (r_j == c_N_LAST) begin
                        r_state <= S_FETCH;
                        r_i     <= r_i + 1'b1;
                        r_j     <= '0;
                        r_xrow  <= r_xrow + c_K;
                        r_xa    <= r_xrow + c_K;
                        r_ya    <= '0;
                    end else begin
                        r_state <= S_FETCH;
                        r_j     <= r_j + 1'b1;
                        r_xa    <= r_xrow;
                        r_ya    <= r_j + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_reject = r_wr_reject;
    assign z_dout    = r_zdout;

endmodule
`default_nettype wire

// File: tb/tb_matmul_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_gen
// Brief    : Directed self-checking bench for matmul_gen (2x3x2 and 1x1x1).
// Revision : 1.0
// ============================================================================
module tb_matmul_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x_din, y_din;
    logic [11:0] x_wa, y_wa, z_ra;
    logic        start_a, xwe_a, ywe_a, busy_a, done_a, rej_a;
    logic        start_b, xwe_b, ywe_b, busy_b, done_b, rej_b;
    logic [31:0] zd_a, zd_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matmul_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .M_DIM(2), .K_DIM(3), .N_DIM(2)) u_dut_a (
        .clock(clk), .reset(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .x_din(x_din), .x_wr_addr(x_wa), .x_wr_en(xwe_a),
        .y_din(y_din), .y_wr_addr(y_wa), .y_wr_en(ywe_a),
        .z_rd_addr(z_ra), .z_dout(zd_a), .wr_reject(rej_a)
    );

    matmul_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .M_DIM(1), .K_DIM(1), .N_DIM(1)) u_dut_b (
        .clock(clk), .reset(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .x_din(x_din), .x_wr_addr(x_wa), .x_wr_en(xwe_b),
        .y_din(y_din), .y_wr_addr(y_wa), .y_wr_en(ywe_b),
        .z_rd_addr(z_ra), .z_dout(zd_b), .wr_reject(rej_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All stimulus is applied on the falling edge; tasks return on a falling edge.
    task automatic write(input bit b, input bit xe, input bit ye,
                         input logic [11:0] xa, input logic [31:0] xd,
                         input logic [11:0] ya, input logic [31:0] yd);
        x_wa = xa; x_din = xd; y_wa = ya; y_din = yd;
        if (b) begin xwe_b = xe; ywe_b = ye; end
        else   begin xwe_a = xe; ywe_a = ye; end
        @(negedge clk);
        xwe_a = 1'b0; ywe_a = 1'b0; xwe_b = 1'b0; ywe_b = 1'b0;
    endtask

    task automatic run(input bit b, output int dcyc, output int dcnt);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        dcyc = -1;
        dcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
            if (b ? done_b : done_a) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
        end
    endtask

    task automatic readz(input bit b, input logic [11:0] addr, input logic [31:0] exp, input string tag);
        z_ra = addr;
        @(negedge clk);
        check(tag, b ? zd_b : zd_a, exp);
    endtask

    initial begin
        int dcyc, dcnt, rej_first, rej_cnt;
        rst = 1'b1;
        start_a = 1'b0; xwe_a = 1'b0; ywe_a = 1'b0;
        start_b = 1'b0; xwe_b = 1'b0; ywe_b = 1'b0;
        x_din = '0; y_din = '0; x_wa = '0; y_wa = '0; z_ra = '0;
        #1;
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_done", {31'b0, done_a}, 32'd0);
        check("rst_rej",  {31'b0, rej_a},  32'd0);
        check("rst_zdout", zd_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // X[1][2] is left at 0 here; the write accepted with start supplies 6.
        write(0, 1, 1, 12'd0, 32'd1, 12'd0, 32'd7);
        write(0, 1, 1, 12'd1, 32'd2, 12'd1, 32'd8);
        write(0, 1, 1, 12'd2, 32'd3, 12'd2, 32'd9);
        write(0, 1, 1, 12'd3, 32'd4, 12'd3, 32'd10);
        write(0, 1, 1, 12'd4, 32'd5, 12'd4, 32'd11);
        write(0, 1, 1, 12'd5, 32'd0, 12'd5, 32'd12);

        // Run 1: write with start, ignored restart at cycle 3, dropped write at cycle 5.
        start_a = 1'b1; xwe_a = 1'b1; x_wa = 12'd5; x_din = 32'd6;
        dcyc = -1; dcnt = 0; rej_first = -1; rej_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_c1", {31'b0, busy_a}, 32'd1);
            if (done_a) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
                check("busy_at_done", {31'b0, busy_a}, 32'd1);
            end
            if (rej_a) begin
                rej_cnt++;
                if (rej_first < 0) rej_first = c;
            end
            start_a = (c == 3);
            xwe_a   = (c == 5);
            if (c == 5) begin x_wa = 12'd0; x_din = 32'd100; end
        end
        check("done_cycle", dcyc, 32'd21);
        check("done_count", dcnt, 32'd1);
        check("rej_cycle", rej_first, 32'd6);
        check("rej_count", rej_cnt, 32'd1);
        check("busy_after", {31'b0, busy_a}, 32'd0);
        readz(0, 12'd0, 32'd58,  "z00");
        readz(0, 12'd1, 32'd64,  "z01");
        readz(0, 12'd2, 32'd139, "z10");
        readz(0, 12'd3, 32'd154, "z11");
        readz(0, 12'd4, 32'd0,   "z_oor4");
        readz(0, 12'd4095, 32'd0, "z_oor_max");

        // Mid-run reset: X[0][0]=2 gives Z[0][0]=65 stored before reset, Z[0][1] untouched.
        write(0, 1, 0, 12'd0, 32'd2, 12'd0, 32'd0);
        readz(0, 12'd0, 32'd58, "z00_pre");
        start_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy_a}, 32'd0);
        check("midrst_done", {31'b0, done_a}, 32'd0);
        check("midrst_zdout", zd_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_a) dcnt++;
        end
        check("midrst_nodone", dcnt, 32'd0);
        readz(0, 12'd0, 32'd65, "z00_kept");
        readz(0, 12'd1, 32'd64, "z01_unwritten");
        run(0, dcyc, dcnt);
        check("rerun_cycle", dcyc, 32'd21);
        check("rerun_count", dcnt, 32'd1);
        readz(0, 12'd1, 32'd72,  "rerun_z01");
        readz(0, 12'd3, 32'd154, "rerun_z11");

        // 1x1x1: signed product and wrap-around.
        write(1, 1, 1, 12'd0, 32'hFFFF_FFFD, 12'd0, 32'd4);
        run(1, dcyc, dcnt);
        check("b_done_cycle", dcyc, 32'd4);
        check("b_done_count", dcnt, 32'd1);
        readz(1, 12'd0, 32'hFFFF_FFF4, "b_neg");
        write(1, 1, 1, 12'd0, 32'h8000_0000, 12'd0, 32'd2);
        run(1, dcyc, dcnt);
        readz(1, 12'd0, 32'h0000_0000, "b_wrap");

        // Out-of-range write is dropped and flagged for one cycle.
        write(1, 1, 0, 12'd1, 32'd9, 12'd0, 32'd0);
        check("b_oor_rej", {31'b0, rej_b}, 32'd1);
        @(negedge clk);
        check("b_oor_rej_clr", {31'b0, rej_b}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
